mic1_uart_io: RTL and testbench

//  Memory-mapped UART peripheral for the Mic-1 SoC, serving the byte IO address at IO_ADDR.

---
 rtl/mic1_uart_io.sv | 212 +++++++++++++++++++++
 tb/tb_mic1_uart_io.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mic1_uart_io.sv
// Memory-mapped 8N1 UART for the Mic-1 data port: one byte register at IO_ADDR,
// reads pop the RX FIFO (0x00 when empty), writes push the TX FIFO.
module mic1_uart_io #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] IO_ADDR    = 32'hFFFFFFFD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_wdata,
    output logic [31:0] io_rdata,
    output logic        io_sel,
    input  logic        ser_rx,
    output logic        ser_tx,
    output logic        rx_overflow,
    output logic        rx_frame_err,
    output logic        tx_overflow,
    output logic        tx_busy
);
    localparam int unsigned DIV = CLK_FREQ / BAUD;
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned PW  = AW + 1;
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    rx_state_t     rx_state_q, rx_state_d;
    tx_state_t     tx_state_q, tx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d;
    logic          rx_s1_q, rx_s_q;
    logic [PW-1:0] rx_wp_q, rx_rp_q, tx_wp_q, tx_rp_q, tx_wp_d, tx_rp_d;
    logic [7:0]    rx_mem_q [FIFO_DEPTH];
    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic          ser_tx_q, ser_tx_d, tx_busy_q, tx_busy_d;
    logic          io_sel_q;
    logic [31:0]   io_rdata_q;
    logic          rx_ovf_q, rx_ferr_q, tx_ovf_q;
    logic          rx_push_req, rx_ferr_set, tx_pop;
    logic          wdata_unused;

    wire hit_rd   = mem_read  && (mem_addr == IO_ADDR);
    wire hit_wr   = mem_write && (mem_addr == IO_ADDR);
    wire rx_empty = (rx_wp_q == rx_rp_q);
    wire rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
    wire tx_empty = (tx_wp_q == tx_rp_q);
    wire tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
    wire rx_pop   = hit_rd && !rx_empty;
    // A same-cycle pop frees the slot the incoming byte needs.
    wire rx_push  = rx_push_req && (!rx_full || rx_pop);
    wire tx_push  = hit_wr && !tx_full;

    assign wdata_unused = ^mem_wdata[31:8];

    // RX next-state: mid-bit sampling driven by a down-counter.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_sh_d     = rx_sh_q;
        rx_push_req = 1'b0;
        rx_ferr_set = 1'b0;
        case (rx_state_q)
            RX_IDLE: if (!rx_s_q) begin
                rx_state_d = RX_START;
                rx_cnt_d   = HALF_M1;
            end
            RX_START: if (rx_cnt_q == '0) begin
                rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
                rx_cnt_d   = DIV_M1;
                rx_bit_d   = 3'd0;
            end else rx_cnt_d = rx_cnt_q - CW'(1);
            RX_DATA: if (rx_cnt_q == '0) begin
                rx_sh_d  = {rx_s_q, rx_sh_q[7:1]};
                rx_cnt_d = DIV_M1;
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                else                  rx_bit_d   = rx_bit_q + 3'd1;
            end else rx_cnt_d = rx_cnt_q - CW'(1);
            RX_STOP: if (rx_cnt_q == '0) begin
                if (rx_s_q) begin
                    rx_push_req = 1'b1;
                    rx_state_d  = RX_IDLE;
                end else begin
                    rx_ferr_set = 1'b1;
                    rx_state_d  = RX_WAIT;
                end
            end else rx_cnt_d = rx_cnt_q - CW'(1);
            RX_WAIT: if (rx_s_q) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // TX next-state: the end of a stop bit chains straight into the next start bit.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        ser_tx_d   = ser_tx_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: if (!tx_empty) begin
                tx_pop     = 1'b1;
                tx_sh_d    = tx_mem_q[tx_rp_q[AW-1:0]];
                tx_state_d = TX_START;
                tx_cnt_d   = DIV_M1;
                ser_tx_d   = 1'b0;
            end
            TX_START: if (tx_cnt_q == '0) begin
                tx_state_d = TX_DATA;
                tx_cnt_d   = DIV_M1;
                tx_bit_d   = 3'd0;
                ser_tx_d   = tx_sh_q[0];
            end else tx_cnt_d = tx_cnt_q - CW'(1);
            TX_DATA: if (tx_cnt_q == '0) begin
                tx_cnt_d = DIV_M1;
                if (tx_bit_q == 3'd7) begin
                    tx_state_d = TX_STOP;
                    ser_tx_d   = 1'b1;
                end else begin
                    tx_bit_d = tx_bit_q + 3'd1;
                    tx_sh_d  = {1'b1, tx_sh_q[7:1]};
                    ser_tx_d = tx_sh_q[1];
                end
            end else tx_cnt_d = tx_cnt_q - CW'(1);
            TX_STOP: if (tx_cnt_q == '0) begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_sh_d    = tx_mem_q[tx_rp_q[AW-1:0]];
                    tx_state_d = TX_START;
                    tx_cnt_d   = DIV_M1;
                    ser_tx_d   = 1'b0;
                end else tx_state_d = TX_IDLE;
            end else tx_cnt_d = tx_cnt_q - CW'(1);
            default: tx_state_d = TX_IDLE;
        endcase
        tx_wp_d   = tx_wp_q + PW'(tx_push);
        tx_rp_d   = tx_rp_q + PW'(tx_pop);
        tx_busy_d = (tx_state_d != TX_IDLE) || (tx_wp_d != tx_rp_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1_q    <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            ser_tx_q   <= 1'b1;
            tx_busy_q  <= 1'b0;
            io_sel_q   <= 1'b0;
            io_rdata_q <= '0;
            rx_ovf_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
            tx_ovf_q   <= 1'b0;
        end else begin
            rx_s1_q    <= ser_rx;
            rx_s_q     <= rx_s1_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_wp_q    <= rx_wp_q + PW'(rx_push);
            rx_rp_q    <= rx_rp_q + PW'(rx_pop);
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_wp_q    <= tx_wp_d;
            tx_rp_q    <= tx_rp_d;
            ser_tx_q   <= ser_tx_d;
            tx_busy_q  <= tx_busy_d;
            io_sel_q   <= hit_rd;
            if (hit_rd)
                io_rdata_q <= rx_empty ? 32'h0 : {24'h0, rx_mem_q[rx_rp_q[AW-1:0]]};
            if (rx_push_req && rx_full && !rx_pop) rx_ovf_q <= 1'b1;
            if (rx_ferr_set)                       rx_ferr_q <= 1'b1;
            if (hit_wr && tx_full)                 tx_ovf_q <= 1'b1;
        end
    end

    // FIFO storage carries no reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem_q[rx_wp_q[AW-1:0]] <= rx_sh_q;
        if (tx_push) tx_mem_q[tx_wp_q[AW-1:0]] <= mem_wdata[7:0];
    end

    assign io_rdata     = io_rdata_q;
    assign io_sel       = io_sel_q;
    assign ser_tx       = ser_tx_q;
    assign rx_overflow  = rx_ovf_q;
    assign rx_frame_err = rx_ferr_q;
    assign tx_overflow  = tx_ovf_q;
    assign tx_busy      = tx_busy_q;
endmodule

// File: tb/tb_mic1_uart_io.sv
// Bench for mic1_uart_io: queue-based FIFO/line model checked every cycle, plus literal checks.
module tb_mic1_uart_io;
    localparam int unsigned DIV    = 16;
    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] IO_A   = 32'hFFFFFFFD;
    // Edges from the first start-bit edge to the stop-bit sample: sync, half bit, nine bits.
    localparam int          RX_LAT = 2 + DIV / 2 + 9 * DIV;

    logic        clk, reset;
    logic [31:0] mem_addr, mem_wdata, io_rdata;
    logic        mem_read, mem_write, io_sel, ser_rx, ser_tx;
    logic        rx_overflow, rx_frame_err, tx_overflow, tx_busy;

    mic1_uart_io #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(4), .IO_ADDR(32'hFFFFFFFD)) dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_read(mem_read),
        .mem_write(mem_write), .mem_wdata(mem_wdata), .io_rdata(io_rdata), .io_sel(io_sel),
        .ser_rx(ser_rx), .ser_tx(ser_tx), .rx_overflow(rx_overflow),
        .rx_frame_err(rx_frame_err), .tx_overflow(tx_overflow), .tx_busy(tx_busy));

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] b;
        bit         ok;
    } rx_ev_t;

    int          checks = 0, errors = 0, cyc = 0, last_due = 0;
    bit          cmp_en = 0, rx_done = 0;
    logic [7:0]  m_rxq[$], m_txq[$];
    rx_ev_t      ev_q[$];
    logic        m_sel = 0;
    logic [31:0] m_rdata = 0;
    bit          m_rxovf = 0, m_ferr = 0, m_txovf = 0, m_txact = 0;
    int          m_txk = 0;
    logic [7:0]  m_txb = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic m_ser();
        int idx;
        if (!m_txact) return 1'b1;
        idx = m_txk / DIV;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return m_txb[idx-1];
    endfunction

    task automatic model_step();
        bit     hrd, hwr, txfull;
        rx_ev_t e;
        if (reset) begin
            m_rxq.delete(); m_txq.delete(); ev_q.delete();
            m_sel = 0; m_rdata = 0; m_rxovf = 0; m_ferr = 0; m_txovf = 0; m_txact = 0;
            return;
        end
        hrd    = mem_read  && (mem_addr == IO_A);
        hwr    = mem_write && (mem_addr == IO_A);
        txfull = (m_txq.size() >= DEPTH);
        if (m_txact) begin
            m_txk++;
            if (m_txk == 10 * DIV) m_txact = 0;
        end
        if (!m_txact && m_txq.size() > 0) begin
            m_txb = m_txq.pop_front(); m_txact = 1; m_txk = 0;
        end
        if (hwr) begin
            if (txfull) m_txovf = 1;
            else        m_txq.push_back(mem_wdata[7:0]);
        end
        m_sel = hrd;
        if (hrd) m_rdata = (m_rxq.size() > 0) ? {24'h0, m_rxq.pop_front()} : 32'h0;
        if (ev_q.size() > 0 && ev_q[0].due == cyc) begin
            e = ev_q.pop_front();
            if (!e.ok)                    m_ferr = 1;
            else if (m_rxq.size() < DEPTH) m_rxq.push_back(e.b);
            else                          m_rxovf = 1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("io_sel", {31'h0, io_sel}, {31'h0, m_sel});
            chk("io_rdata", io_rdata, m_rdata);
            chk("ser_tx", {31'h0, ser_tx}, {31'h0, m_ser()});
            chk("tx_busy", {31'h0, tx_busy}, {31'h0, (m_txact || m_txq.size() > 0)});
            chk("rx_overflow", {31'h0, rx_overflow}, {31'h0, m_rxovf});
            chk("rx_frame_err", {31'h0, rx_frame_err}, {31'h0, m_ferr});
            chk("tx_overflow", {31'h0, tx_overflow}, {31'h0, m_txovf});
        end
    end

    task automatic send_frame(input logic [7:0] b, input bit ok, input int gap);
        @(negedge clk);
        last_due = cyc + 1 + RX_LAT;
        ev_q.push_back('{due: last_due, b: b, ok: ok});
        ser_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        ser_rx = ok;
        repeat (DIV) @(negedge clk);
        ser_rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic bus(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        mem_addr = addr; mem_read = rd; mem_write = wr; mem_wdata = wd;
        @(negedge clk);
        mem_addr = 32'h0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic rd_check(input string nm, input logic [7:0] exp);
        bus(1'b1, 1'b0, IO_A, 32'h0);
        chk(nm, io_rdata, {24'h0, exp});
        chk({nm, "_sel"}, {31'h0, io_sel}, 32'h1);
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic wait_tx_idle(input int budget);
        int n = 0;
        while (tx_busy && n < budget) begin
            @(negedge clk); n++;
        end
        chk("tx_idle_timeout", {31'h0, tx_busy}, 32'h0);
    endtask

    task automatic chk_flags0(input string nm);
        chk({nm, "_rxovf"}, {31'h0, rx_overflow}, 32'h0);
        chk({nm, "_ferr"}, {31'h0, rx_frame_err}, 32'h0);
        chk({nm, "_txovf"}, {31'h0, tx_overflow}, 32'h0);
    endtask

    initial begin
        #300_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [9:0] got;
        int         n, r;
        clk = 1'b0; reset = 1'b1; ser_rx = 1'b1;
        mem_addr = 32'h0; mem_read = 1'b0; mem_write = 1'b0; mem_wdata = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0; cmp_en = 1'b1;
        chk("rst_io_sel", {31'h0, io_sel}, 32'h0);
        chk("rst_io_rdata", io_rdata, 32'h0);
        chk("rst_ser_tx", {31'h0, ser_tx}, 32'h1);
        chk("rst_tx_busy", {31'h0, tx_busy}, 32'h0);
        chk_flags0("rst");

        send_frame(8'h33, 1'b1, 6);
        rd_check("t1_rd33", 8'h33);
        rd_check("t1_rd_empty", 8'h00);
        chk_flags0("t1");

        bus(1'b0, 1'b1, IO_A, 32'h0000_0A41);
        chk("t2_idle_c1", {31'h0, ser_tx}, 32'h1);
        @(negedge clk);
        chk("t2_start_c2", {31'h0, ser_tx}, 32'h0);
        repeat (8) @(negedge clk);
        got[0] = ser_tx;
        for (int k = 1; k < 10; k++) begin
            repeat (DIV) @(negedge clk);
            got[k] = ser_tx;
        end
        chk("t2_frame", {22'h0, got}, 32'h282);
        wait_tx_idle(100);

        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 6);
        chk("t3_rxovf", {31'h0, rx_overflow}, 32'h1);
        for (int i = 1; i <= 4; i++) rd_check("t3_rd", 8'(i));
        rd_check("t3_rd_empty", 8'h00);

        do_reset();
        send_frame(8'h35, 1'b0, 8);
        chk("t4_ferr", {31'h0, rx_frame_err}, 32'h1);
        rd_check("t4_rd_empty", 8'h00);
        @(negedge clk); ser_rx = 1'b0;
        repeat (6) @(negedge clk); ser_rx = 1'b1;
        repeat (40) @(negedge clk);
        rd_check("t4_glitch_empty", 8'h00);
        chk("t4_glitch_rxovf", {31'h0, rx_overflow}, 32'h0);

        do_reset();
        for (int i = 0; i < 4; i++) send_frame(8'hA0 + 8'(i), 1'b1, 6);
        fork
            send_frame(8'hA4, 1'b1, 6);
            begin
                repeat (4) @(negedge clk);
                n = 0;
                while (cyc != last_due - 1 && n < 400) begin
                    @(negedge clk); n++;
                end
                chk("t5_align_timeout", {31'h0, (n >= 400)}, 32'h0);
                mem_addr = IO_A; mem_read = 1'b1;
                @(negedge clk);
                mem_addr = 32'h0; mem_read = 1'b0;
                chk("t5_rd_oldest", io_rdata, 32'hA0);
            end
        join
        chk("t5_rxovf", {31'h0, rx_overflow}, 32'h0);
        for (int i = 1; i <= 4; i++) rd_check("t5_rd", 8'hA0 + 8'(i));
        rd_check("t5_rd_empty", 8'h00);

        fork
            send_frame(8'hF0, 1'b1, 6);
            begin
                bus(1'b0, 1'b1, IO_A, 32'h5A);
                repeat (96) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk("t6_ser_tx", {31'h0, ser_tx}, 32'h1);
                chk("t6_io_sel", {31'h0, io_sel}, 32'h0);
                chk("t6_tx_busy", {31'h0, tx_busy}, 32'h0);
                chk_flags0("t6");
            end
        join
        send_frame(8'h96, 1'b1, 6);
        rd_check("t6_rd96", 8'h96);
        bus(1'b0, 1'b1, IO_A, 32'hC3);
        wait_tx_idle(400);

        fork
            begin
                for (int i = 0; i < 12; i++)
                    send_frame(8'($urandom), ($urandom_range(0, 7) != 0), $urandom_range(6, 30));
                rx_done = 1;
            end
            while (!rx_done) begin
                r = $urandom_range(0, 9);
                case (r)
                    0, 1, 2: bus(1'b1, 1'b0, IO_A, 32'h0);
                    3, 4:    bus(1'b0, 1'b1, IO_A, $urandom);
                    5:       bus(1'b1, 1'b1, IO_A, $urandom);
                    6:       bus(1'b1, 1'b0, IO_A ^ (32'd1 << $urandom_range(0, 31)), 32'h0);
                    7:       bus(1'b0, 1'b1, IO_A ^ (32'd1 << $urandom_range(0, 31)), $urandom);
                    default: @(negedge clk);
                endcase
                repeat ($urandom_range(0, 15)) @(negedge clk);
            end
        join
        repeat (6) bus(1'b1, 1'b0, IO_A, 32'h0);
        wait_tx_idle(2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
